uifbuf_ctrl: RTL and testbench

UIFBUF_CTRL -- requirements
Module: uifbuf_ctrl

---
 rtl/uifbuf_pkg.sv | 8 +
 rtl/uifbuf_stat.sv | 19 +
 rtl/uifbuf_ctrl.sv | 67 ++++++
 tb/tb_uifbuf_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uifbuf_pkg.sv
// uifbuf_pkg: shared types, index width and modulo-increment helper for the frame-buffer ring controller.
package uifbuf_pkg;
    localparam int IDX_W = 8;
    typedef enum logic {W_IDLE, W_BUSY} wstate_t;
    function automatic logic [IDX_W-1:0] mod_inc(input logic [IDX_W-1:0] v, input logic [IDX_W-1:0] n);
        return (v == n - 8'd1) ? '0 : v + 8'd1;
    endfunction
endpackage

// File: rtl/uifbuf_stat.sv
// uifbuf_stat: 16-bit wrapping counters of completed writes and repeated reads.
module uifbuf_stat (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_done,
    input  logic        rd_repeat,
    output logic [15:0] wr_frame_cnt_o,
    output logic [15:0] rd_repeat_cnt_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_frame_cnt_o  <= '0;
            rd_repeat_cnt_o <= '0;
        end else begin
            wr_frame_cnt_o  <= wr_frame_cnt_o + {15'd0, wr_done};
            rd_repeat_cnt_o <= rd_repeat_cnt_o + {15'd0, rd_repeat};
        end
    end
endmodule

// File: rtl/uifbuf_ctrl.sv
// uifbuf_ctrl: frame-buffer ring controller keeping writer and reader on distinct buffers.
// Define UIFBUF_STAT_EN to build the write/repeat statistics counters.
module uifbuf_ctrl
    import uifbuf_pkg::*;
#(
    parameter int BUF_LENTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_fs_i,
    input  logic             wr_fe_i,
    input  logic             rd_fs_i,
    output logic [IDX_W-1:0] wr_bufn_o,
    output logic [IDX_W-1:0] rd_bufn_o,
    output logic             rd_valid_o,
    output logic             wr_err_o,
    output logic [15:0]      wr_frame_cnt_o,
    output logic [15:0]      rd_repeat_cnt_o
);
    localparam logic [IDX_W-1:0] LEN = IDX_W'(BUF_LENTH);
    wstate_t state, state_nx;
    logic [IDX_W-1:0] latest, rd_next, wr_inc, wr_nx;
    logic new_flag, fe_done, avail;
    always_comb begin
        fe_done  = (state == W_BUSY) && wr_fe_i;
        state_nx = (state == W_IDLE) ? (wr_fs_i ? W_BUSY : W_IDLE) : (wr_fe_i ? W_IDLE : W_BUSY);
        avail    = new_flag | fe_done;
        // a frame completing this cycle bypasses straight to the reader
        rd_next  = (rd_fs_i && avail) ? (fe_done ? wr_bufn_o : latest) : rd_bufn_o;
        wr_inc   = mod_inc(wr_bufn_o, LEN);
        wr_nx    = !fe_done ? wr_bufn_o : (wr_inc == rd_next) ? mod_inc(wr_inc, LEN) : wr_inc;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= W_IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_bufn_o  <= '0;
            rd_bufn_o  <= LEN - 8'd1;
            latest     <= '0;
            new_flag   <= 1'b0;
            rd_valid_o <= 1'b0;
            wr_err_o   <= 1'b0;
        end else begin
            wr_bufn_o  <= wr_nx;
            rd_bufn_o  <= rd_next;
            latest     <= fe_done ? wr_bufn_o : latest;
            new_flag   <= avail & ~rd_fs_i;
            rd_valid_o <= rd_valid_o | fe_done;
            wr_err_o   <= (state == W_BUSY) && wr_fs_i && !wr_fe_i;
        end
    end
`ifdef UIFBUF_STAT_EN
    uifbuf_stat u_stat (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_done        (fe_done),
        .rd_repeat      (rd_fs_i & ~avail),
        .wr_frame_cnt_o (wr_frame_cnt_o),
        .rd_repeat_cnt_o(rd_repeat_cnt_o)
    );
`else
    assign wr_frame_cnt_o  = '0;
    assign rd_repeat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_uifbuf_ctrl.sv
// tb_uifbuf_ctrl: directed-vector bench for uifbuf_ctrl with BUF_LENTH=3.
module tb_uifbuf_ctrl;
    logic clk = 1'b0;
    logic rst, wfs, wfe, rfs;
    logic [7:0] wr_bufn, rd_bufn;
    logic rd_valid, wr_err;
    logic [15:0] wr_cnt, rep_cnt;
    int nvec = 0;
    int nerr = 0;
`ifdef UIFBUF_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    uifbuf_ctrl #(.BUF_LENTH(3)) dut (
        .clk_i(clk), .rst_i(rst), .wr_fs_i(wfs), .wr_fe_i(wfe), .rd_fs_i(rfs),
        .wr_bufn_o(wr_bufn), .rd_bufn_o(rd_bufn), .rd_valid_o(rd_valid), .wr_err_o(wr_err),
        .wr_frame_cnt_o(wr_cnt), .rd_repeat_cnt_o(rep_cnt)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic fs, input logic fe, input logic rd);
        @(negedge clk);
        rst = r; wfs = fs; wfe = fe; rfs = rd;
        @(posedge clk);
        #1;
        rst = 1'b0; wfs = 1'b0; wfe = 1'b0; rfs = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (wr_bufn !== 8'd0) begin nerr++; $display("FAIL reset_wr: got %0d exp 0", wr_bufn); end
        nvec++; if (rd_bufn !== 8'd2) begin nerr++; $display("FAIL reset_rd: got %0d exp 2", rd_bufn); end
        nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b exp 0", rd_valid); end
        nvec++; if (wr_err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b exp 0", wr_err); end
        nvec++; if (wr_cnt !== 16'd0 || rep_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", wr_cnt, rep_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        nvec++; if (wr_bufn !== 8'd0 || rd_valid !== 1'b0) begin nerr++; $display("FAIL basic_fs: got wr=%0d v=%b exp wr=0 v=0", wr_bufn, rd_valid); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (wr_bufn !== 8'd1) begin nerr++; $display("FAIL basic_wr: got %0d exp 1", wr_bufn); end
        nvec++; if (rd_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %b exp 1", rd_valid); end
        nvec++; if (rd_bufn !== 8'd2) begin nerr++; $display("FAIL basic_rd_hold: got %0d exp 2", rd_bufn); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        nvec++; if (rd_bufn !== 8'd0 || wr_bufn !== 8'd1) begin nerr++; $display("FAIL basic_rd: got rd=%0d wr=%0d exp rd=0 wr=1", rd_bufn, wr_bufn); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (wr_bufn !== 8'd1 || wr_err !== 1'b0) begin nerr++; $display("FAIL fe_idle: got wr=%0d err=%b exp wr=1 err=0", wr_bufn, wr_err); end
    endtask

    task automatic test_skip();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (wr_bufn !== 8'd1) begin nerr++; $display("FAIL skip_wr1: got %0d exp 1", wr_bufn); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (wr_bufn !== 8'd0) begin nerr++; $display("FAIL skip_wr0: got %0d exp 0", wr_bufn); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        nvec++; if (rd_bufn !== 8'd1) begin nerr++; $display("FAIL skip_rd: got %0d exp 1", rd_bufn); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        nvec++; if (rd_bufn !== 8'd1) begin nerr++; $display("FAIL repeat_rd: got %0d exp 1", rd_bufn); end
        nvec++; if (wr_cnt !== (STAT ? 16'd2 : 16'd0)) begin nerr++; $display("FAIL skip_wrcnt: got %0d exp %0d", wr_cnt, STAT ? 2 : 0); end
        nvec++; if (rep_cnt !== (STAT ? 16'd1 : 16'd0)) begin nerr++; $display("FAIL skip_repcnt: got %0d exp %0d", rep_cnt, STAT ? 1 : 0); end
    endtask

    task automatic test_simul();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        nvec++; if (wr_bufn !== 8'd1 || rd_bufn !== 8'd0) begin nerr++; $display("FAIL simul_pre: got wr=%0d rd=%0d exp wr=1 rd=0", wr_bufn, rd_bufn); end
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        nvec++; if (rd_bufn !== 8'd1) begin nerr++; $display("FAIL simul_rd: got %0d exp 1", rd_bufn); end
        nvec++; if (wr_bufn !== 8'd2) begin nerr++; $display("FAIL simul_wr: got %0d exp 2", wr_bufn); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        nvec++; if (rd_bufn !== 8'd1) begin nerr++; $display("FAIL simul_consumed: got %0d exp 1", rd_bufn); end
    endtask

    task automatic test_abort();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        nvec++; if (wr_err !== 1'b1) begin nerr++; $display("FAIL abort_err: got %b exp 1", wr_err); end
        nvec++; if (wr_bufn !== 8'd0) begin nerr++; $display("FAIL abort_wr: got %0d exp 0", wr_bufn); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        nvec++; if (wr_err !== 1'b0) begin nerr++; $display("FAIL abort_pulse: got %b exp 0", wr_err); end
        nvec++; if (rd_bufn !== 8'd2) begin nerr++; $display("FAIL abort_rd: got %0d exp 2", rd_bufn); end
        nvec++; if (rep_cnt !== (STAT ? 16'd1 : 16'd0)) begin nerr++; $display("FAIL abort_repcnt: got %0d exp %0d", rep_cnt, STAT ? 1 : 0); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (wr_bufn !== 8'd1 || rd_valid !== 1'b1 || wr_err !== 1'b0) begin nerr++; $display("FAIL abort_fe: got wr=%0d v=%b err=%b exp wr=1 v=1 err=0", wr_bufn, rd_valid, wr_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        nvec++; if (wr_bufn !== 8'd0 || rd_bufn !== 8'd2 || rd_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_vals: got wr=%0d rd=%0d v=%b exp 0/2/0", wr_bufn, rd_bufn, rd_valid); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        nvec++; if (rd_bufn !== 8'd2 || rd_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_rd: got rd=%0d v=%b exp rd=2 v=0", rd_bufn, rd_valid); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (wr_bufn !== 8'd0 || rd_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_idle_fe: got wr=%0d v=%b exp wr=0 v=0", wr_bufn, rd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1, i[0]);
            nvec++; if (wr_bufn === rd_bufn || wr_bufn > 8'd2 || rd_bufn > 8'd2) begin nerr++; $display("FAIL b2b_%0d: got wr=%0d rd=%0d exp distinct and <3", i, wr_bufn, rd_bufn); end
        end
        nvec++; if (wr_cnt !== (STAT ? 16'd12 : 16'd0)) begin nerr++; $display("FAIL b2b_wrcnt: got %0d exp %0d", wr_cnt, STAT ? 12 : 0); end
    endtask

    initial begin
        rst = 1'b1; wfs = 1'b0; wfe = 1'b0; rfs = 1'b0;
        test_reset();
        test_basic();
        test_skip();
        test_simul();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
